// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one external FP32 adder between requesters.
// Two-stage pipeline: operand register feeds the adder, result register feeds the response.
module fp_add_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = 5,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_a,
    input  logic [32*NUM_REQ-1:0]    req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic [31:0]              add_a,
    output logic [31:0]              add_b,
    input  logic [31:0]              add_res,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic [ID_W-1:0]          resp_id,
    output logic [TAG_W-1:0]         resp_tag,
    output logic                     busy
);

    logic             s1_valid_q, s1_valid_d;
    logic [31:0]      s1_a_q, s1_a_d;
    logic [31:0]      s1_b_q, s1_b_d;
    logic [ID_W-1:0]  s1_id_q, s1_id_d;
    logic [TAG_W-1:0] s1_tag_q, s1_tag_d;

    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      s2_data_q, s2_data_d;
    logic [ID_W-1:0]  s2_id_q, s2_id_d;
    logic [TAG_W-1:0] s2_tag_q, s2_tag_d;

    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic             s2_free, s1_free, move, accept;
    logic             hi_vld, lo_vld, gnt_vld;
    logic [ID_W-1:0]  hi_idx, lo_idx, gnt_idx;
    logic [31:0]      sel_a, sel_b;
    logic             sel_sub;
    logic [TAG_W-1:0] sel_tag;

    assign s2_free = !s2_valid_q | resp_ready;
    assign s1_free = !s1_valid_q | s2_free;
    assign move    = s1_valid_q & s2_free;
    assign accept  = s1_free & gnt_vld;

    // Two scans: at/above rr_ptr first, then wrap to the lowest index.
    always_comb begin
        hi_vld = 1'b0;
        hi_idx = '0;
        lo_vld = 1'b0;
        lo_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !lo_vld) begin
                lo_vld = 1'b1;
                lo_idx = ID_W'(i);
            end
            if (req_valid[i] && !hi_vld && i >= int'(rr_ptr_q)) begin
                hi_vld = 1'b1;
                hi_idx = ID_W'(i);
            end
        end
        gnt_vld = lo_vld;
        gnt_idx = hi_vld ? hi_idx : lo_idx;
    end

    always_comb begin
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        sel_sub   = 1'b0;
        sel_tag   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) begin
                req_ready[i] = rst_n & accept;
                sel_a        = req_a[32*i +: 32];
                sel_b        = req_b[32*i +: 32];
                sel_sub      = req_sub[i];
                sel_tag      = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_id_d    = s1_id_q;
        s1_tag_d   = s1_tag_q;
        rr_ptr_d   = rr_ptr_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_a_d     = sel_a;
            s1_b_d     = sel_b ^ {sel_sub, 31'b0};
            s1_id_d    = gnt_idx;
            s1_tag_d   = sel_tag;
            rr_ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0
                                                         : gnt_idx + ID_W'(1);
        end else if (move) begin
            s1_valid_d = 1'b0;
        end
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_id_d    = s2_id_q;
        s2_tag_d   = s2_tag_q;
        if (move) begin
            s2_valid_d = 1'b1;
            s2_data_d  = add_res;
            s2_id_d    = s1_id_q;
            s2_tag_d   = s1_tag_q;
        end else if (s2_valid_q && resp_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_id_q    <= '0;
            s1_tag_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_id_q    <= '0;
            s2_tag_q   <= '0;
            rr_ptr_q   <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_id_q    <= s1_id_d;
            s1_tag_q   <= s1_tag_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_id_q    <= s2_id_d;
            s2_tag_q   <= s2_tag_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign add_a      = s1_a_q;
    assign add_b      = s1_b_q;
    assign resp_valid = s2_valid_q;
    assign resp_data  = s2_data_q;
    assign resp_id    = s2_id_q;
    assign resp_tag   = s2_tag_q;
    assign busy       = s1_valid_q | s2_valid_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: integer-valued FP32 operands, real-arithmetic
// adder stand-in, and a queue scoreboard of accepted operations.
module tb_fp_add_arbiter;

    localparam int N  = 2;
    localparam int TW = 5;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [32*N-1:0]   req_a;
    logic [32*N-1:0]   req_b;
    logic [N-1:0]      req_sub;
    logic [TW*N-1:0]   req_tag;
    logic [31:0]       add_a, add_b, add_res;
    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_data;
    logic [IW-1:0]     resp_id;
    logic [TW-1:0]     resp_tag;
    logic              busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] d;
        int          id;
        int          tag;
    } rsp_t;

    rsp_t        exp_q[$];
    int          acc_q[$];
    int          acc_cnt = 0;
    int          rsp_cnt = 0;
    int          m_ptr = 0;
    int          m_i;
    rsp_t        m_e;
    logic [N-1:0] m_er;
    logic [N-1:0] acc_last = '0;

    int          op_x[N];
    int          op_y[N];
    logic        op_s[N];
    logic [TW-1:0] op_t[N];

    logic          stall_prev = 1'b0;
    logic [31:0]   sv_d;
    logic [IW-1:0] sv_id;
    logic [TW-1:0] sv_tag;

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        if (f[30:23] == 8'd0) return 0.0;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'b0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] i2f(input int v);
        return r2f(real'(v));
    endfunction

    // Stand-in for the external combinational adder.
    assign add_res = r2f(f2r(add_a) + f2r(add_b));

    fp_add_arbiter #(
        .NUM_REQ(N),
        .TAG_W  (TW),
        .ID_W   (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sub   (req_sub),
        .req_tag   (req_tag),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_res   (add_res),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_id   (resp_id),
        .resp_tag  (resp_tag),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_op(input int i, input int x, input int y,
                          input logic s, input logic [TW-1:0] t,
                          input logic v);
        op_x[i] = x;
        op_y[i] = y;
        op_s[i] = s;
        op_t[i] = t;
        req_a[32*i +: 32]  = i2f(x);
        req_b[32*i +: 32]  = i2f(y);
        req_sub[i]         = s;
        req_tag[TW*i +: TW] = t;
        req_valid[i]       = v;
    endtask

    task automatic rnd_op(input int i);
        set_op(i, int'($urandom_range(2000)) - 1000,
               int'($urandom_range(2000)) - 1000,
               1'($urandom), TW'($urandom), 1'b1);
    endtask

    task automatic reroll_accepted();
        for (int i = 0; i < N; i++)
            if (acc_last[i]) rnd_op(i);
    endtask

    task automatic wait_ready(input int i);
        int t = 0;
        #1;
        while (!req_ready[i] && t < 10) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("acc_wait", 32'(req_ready[i]), 32'd1);
    endtask

    task automatic one_op(input int i, input int x, input int y,
                          input logic s, input logic [TW-1:0] t,
                          input logic [31:0] ed, input logic [31:0] eb);
        @(posedge clk);
        #1;
        set_op(i, x, y, s, t, 1'b1);
        wait_ready(i);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        chk("lat_early", 32'(resp_valid), 32'd0);
        chk("add_b", add_b, eb);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(resp_valid), 32'd1);
        chk("one_data", resp_data, ed);
        chk("one_id", 32'(resp_id), 32'(i));
        chk("one_tag", 32'(resp_tag), 32'(t));
    endtask

    // Scoreboard: grant rule, occupancy, ordering and hold-under-stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_ptr      = 0;
            stall_prev = 1'b0;
            acc_last   = '0;
        end else begin
            m_er = '0;
            if (exp_q.size() < 2 || resp_ready)
                for (int k = 0; k < N; k++) begin
                    m_i = (m_ptr + k) % N;
                    if (req_valid[m_i] && m_er == '0) m_er[m_i] = 1'b1;
                end
            chk("ready", 32'(req_ready), 32'(m_er));
            chk("busy", 32'(busy), 32'(exp_q.size() != 0));
            if (stall_prev) begin
                chk("hold_valid", 32'(resp_valid), 32'd1);
                chk("hold_data", resp_data, sv_d);
                chk("hold_id", 32'(resp_id), 32'(sv_id));
                chk("hold_tag", 32'(resp_tag), 32'(sv_tag));
            end
            acc_last = '0;
            if (resp_valid && resp_ready) begin
                rsp_cnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious", 32'(resp_valid), 32'd0);
                end else begin
                    m_e = exp_q.pop_front();
                    chk("rsp_data", resp_data, m_e.d);
                    chk("rsp_id", 32'(resp_id), 32'(m_e.id));
                    chk("rsp_tag", 32'(resp_tag), 32'(m_e.tag));
                end
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    m_e.d   = i2f(op_x[i] + (op_s[i] ? -op_y[i] : op_y[i]));
                    m_e.id  = i;
                    m_e.tag = int'(op_t[i]);
                    exp_q.push_back(m_e);
                    acc_q.push_back(i);
                    acc_cnt++;
                    acc_last[i] = 1'b1;
                    m_ptr = (i + 1) % N;
                end
            end
            stall_prev = resp_valid && !resp_ready;
            sv_d   = resp_data;
            sv_id  = resp_id;
            sv_tag = resp_tag;
        end
    end

    initial begin
        int a0, r0, q0, t;
        logic [31:0] held;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_sub    = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_op(i, 0, 0, 1'b0, '0, 1'b0);

        #12;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_add_a", add_a, 32'd0);
        chk("rst_add_b", add_b, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_tag", 32'(resp_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        one_op(0, 1, 2, 1'b0, 5'd5, 32'h4040_0000, 32'h4000_0000);
        one_op(1, 3, 1, 1'b1, 5'd9, 32'h4000_0000, 32'hBF80_0000);
        one_op(0, 1, -1, 1'b0, 5'd3, 32'h0000_0000, 32'hBF80_0000);
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy), 32'd0);

        a0 = acc_cnt;
        r0 = rsp_cnt;
        q0 = acc_q.size();
        rnd_op(0);
        rnd_op(1);
        repeat (10) begin
            @(posedge clk);
            #1;
            reroll_accepted();
        end
        chk("rr_accepts", 32'(acc_cnt - a0), 32'd10);
        chk("rr_gapless", 32'(rsp_cnt - r0), 32'd8);
        for (int k = 1; k < 10; k++)
            chk("rr_alt", 32'(acc_q[q0+k]), 32'(acc_q[q0+k-1] ^ 1));
        req_valid = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rr_drain", 32'(busy), 32'd0);

        resp_ready = 1'b0;
        a0 = acc_cnt;
        rnd_op(0);
        rnd_op(1);
        repeat (5) begin
            @(posedge clk);
            #1;
            reroll_accepted();
        end
        chk("bp_accepts", 32'(acc_cnt - a0), 32'd2);
        chk("bp_ready", 32'(req_ready), 32'd0);
        chk("bp_valid", 32'(resp_valid), 32'd1);
        held = resp_data;
        @(posedge clk);
        #1;
        chk("bp_hold", resp_data, held);
        resp_ready = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            reroll_accepted();
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drain_busy", 32'(busy), 32'd0);
        chk("bp_drain_q", 32'(exp_q.size()), 32'd0);

        resp_ready = 1'b0;
        rnd_op(0);
        rnd_op(1);
        repeat (3) begin
            @(posedge clk);
            #1;
            reroll_accepted();
        end
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2;
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #2;
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("post_rst_stale", 32'(resp_valid), 32'd0);
        end
        rnd_op(1);
        rnd_op(0);
        #1;
        chk("post_rst_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        repeat (800) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (!req_valid[i] || acc_last[i]) begin
                    if ($urandom_range(99) < 60) rnd_op(i);
                    else req_valid[i] = 1'b0;
                end
            resp_ready = ($urandom_range(99) < 65);
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        t = 0;
        while (busy && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("final_busy", 32'(busy), 32'd0);
        chk("final_q", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
